// File: rtl/pipelined_carry_adder_pkg.sv
// Shared constants, types and helpers for the pipelined carry adder.
package pipelined_carry_adder_pkg;

  localparam int unsigned DEF_WIDTH  = 32;
  localparam int unsigned DEF_STAGES = 4;
  localparam int unsigned DEF_CHUNK  = DEF_WIDTH / DEF_STAGES;

  typedef logic [DEF_WIDTH-1:0] word_t;

  // Per-stage payload at the default geometry.
  typedef struct packed {
    logic  valid;
    word_t a;
    word_t b;
    word_t sum;
    logic  carry;
  } stage_t;

  // True when WIDTH splits evenly into STAGES slices with 1 <= STAGES <= WIDTH.
  function automatic bit split_ok(input int unsigned width, input int unsigned stages);
    return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

  // Full-adder cell: returns {carry_out, sum}.
  function automatic logic [1:0] fa(input logic a, input logic b, input logic c);
    return {(a & b) | (c & (a ^ b)), a ^ b ^ c};
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational CHUNK-bit ripple adder built from the full-adder cell.
module adder_slice
  import pipelined_carry_adder_pkg::*;
#(
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] carry_c;

  // Ripple the carry through the slice one FA at a time.
  always_comb begin
    carry_c    = '0;
    sum        = '0;
    carry_c[0] = cin;
    for (int i = 0; i < int'(CHUNK); i++) begin
      {carry_c[i+1], sum[i]} = fa(a[i], b[i], carry_c[i]);
    end
  end

  assign cout = carry_c[CHUNK];
  assign cmsb = carry_c[CHUNK-1];

endmodule

// File: rtl/pipelined_carry_adder.sv
// Elastic STAGES-deep add/subtract pipeline; each stage ripples one CHUNK slice.
module pipelined_carry_adder
  import pipelined_carry_adder_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_carry,
  output logic             out_ovf
);

  // An illegal split collapses the slice width so elaboration breaks visibly.
  localparam int unsigned CHUNK = split_ok(WIDTH, STAGES) ? WIDTH / STAGES : 0;

  // Operands ride along in full so every stage sees a uniform payload;
  // bits already consumed are dead logic and trim away in synthesis.
  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             ovf;
  } pipe_t;

  pipe_t            st_q   [STAGES];
  pipe_t            st_d   [STAGES];
  pipe_t            src_c  [STAGES];
  logic [STAGES:0]  rdy_c;

  logic [CHUNK-1:0] sl_a    [STAGES];
  logic [CHUNK-1:0] sl_b    [STAGES];
  logic [CHUNK-1:0] sl_sum  [STAGES];
  logic             sl_cin  [STAGES];
  logic             sl_cout [STAGES];
  logic             sl_cmsb [STAGES];

  // Ready chain, per-stage sources (operand conditioning at entry) and slice operands.
  always_comb begin
    rdy_c         = '0;
    rdy_c[STAGES] = out_ready;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      rdy_c[k] = !st_q[k].valid || rdy_c[k+1];
    end

    src_c[0].valid = in_valid;
    src_c[0].a     = in_a;
    src_c[0].b     = in_sub ? ~in_b : in_b;
    src_c[0].sum   = '0;
    src_c[0].carry = in_sub | in_cin;
    src_c[0].ovf   = 1'b0;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_c[k] = st_q[k-1];
    end

    for (int k = 0; k < int'(STAGES); k++) begin
      sl_a[k]   = src_c[k].a[k*CHUNK +: CHUNK];
      sl_b[k]   = src_c[k].b[k*CHUNK +: CHUNK];
      sl_cin[k] = src_c[k].carry;
    end
  end

  // One ripple slice per stage.
  for (genvar g = 0; g < STAGES; g++) begin : g_slice
    adder_slice #(.CHUNK(CHUNK)) u_slice (
      .a    (sl_a[g]),
      .b    (sl_b[g]),
      .cin  (sl_cin[g]),
      .sum  (sl_sum[g]),
      .cout (sl_cout[g]),
      .cmsb (sl_cmsb[g])
    );
  end

  // Stage next-state: load when ready, otherwise hold; data only moves with a valid entry.
  always_comb begin
    for (int k = 0; k < int'(STAGES); k++) begin
      st_d[k] = st_q[k];
      if (rdy_c[k]) begin
        st_d[k].valid = src_c[k].valid;
        if (src_c[k].valid) begin
          st_d[k].a                       = src_c[k].a;
          st_d[k].b                       = src_c[k].b;
          st_d[k].sum                     = src_c[k].sum;
          st_d[k].sum[k*CHUNK +: CHUNK]   = sl_sum[k];
          st_d[k].carry                   = sl_cout[k];
          st_d[k].ovf                     = sl_cout[k] ^ sl_cmsb[k];
        end
      end
    end
  end

  // Stage registers; reset discards every in-flight entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        st_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign in_ready  = rdy_c[0];
  assign out_valid = st_q[STAGES-1].valid;
  assign out_sum   = st_q[STAGES-1].sum;
  assign out_carry = st_q[STAGES-1].carry;
  assign out_ovf   = st_q[STAGES-1].ovf;

endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Scoreboard bench for pipelined_carry_adder: directed vectors, backpressure,
// mid-stream reset, and a STAGES sweep at full throughput.
module tb_pipelined_carry_adder;

  localparam int unsigned W       = 32;
  localparam int          MAIN_ST = 4;
  localparam int          N_SW    = 1000;

  typedef struct {
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    int           cyc;
    bit           lat;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_sub;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_carry;
  logic         out_ovf;

  logic         sw_valid;
  logic [W-1:0] sw_a;
  logic [W-1:0] sw_b;
  logic         sw_sub;
  logic         sw_cin;
  bit           sw_done;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   occ     = 0;
  bit   lat_en  = 1'b1;
  bit   saw_stall = 1'b0;
  exp_t mq[$];

  logic [W-1:0] bp_a   [10] = '{32'h00000001, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h12345678,
                                32'hDEADBEEF, 32'h00000000, 32'h55555555, 32'hCAFEF00D, 32'h0000FFFF};
  logic [W-1:0] bp_b   [10] = '{32'h00000001, 32'h00000001, 32'h7FFFFFFF, 32'h00000001, 32'h87654321,
                                32'h21524111, 32'h00000001, 32'hAAAAAAAA, 32'h35010FF3, 32'hFFFF0001};
  logic         bp_sub [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic         bp_cin [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  pipelined_carry_adder #(.WIDTH(W), .STAGES(MAIN_ST)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: widen to WIDTH+1 bits and read carry/overflow from the sign rule.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic sub, input logic cin);
    logic [W-1:0] bb;
    logic [W:0]   f;
    exp_t         e;
    bb      = sub ? ~b : b;
    f       = {1'b0, a} + {1'b0, bb} + (W+1)'(sub ? 1'b1 : cin);
    e.sum   = f[W-1:0];
    e.carry = f[W];
    e.ovf   = (a[W-1] == bb[W-1]) && (f[W-1] != a[W-1]);
    e.cyc   = 0;
    e.lat   = 1'b0;
    return e;
  endfunction

  function automatic exp_t mk(input logic [W-1:0] s, input logic c, input logic o);
    exp_t e;
    e.sum = s; e.carry = c; e.ovf = o; e.cyc = 0; e.lat = 1'b0;
    return e;
  endfunction

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic sub, input logic cin, input exp_t e);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_sub   = sub;
    in_cin   = cin;
    in_valid = 1'b1;
    for (int w = 0; w < 200 && !ok; w++) begin
      @(negedge clk);
      if (in_ready) begin
        e.cyc = cyc;
        e.lat = lat_en;
        mq.push_back(e);
        ok = 1'b1;
      end
    end
    chk("send_accepted", 64'(ok), 64'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int w = 0; w < 100 && !done; w++) begin
      @(negedge clk);
      done = (mq.size() == 0);
    end
    chk("drain_empty", 64'(mq.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  // Main monitor: ready model, output vs scoreboard head (held while stalled), latency.
  always @(negedge clk) begin
    if (!rst_n) begin
      occ = 0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(out_ready || (occ < MAIN_ST)));
      if (!in_ready) saw_stall = 1'b1;
      if (out_valid) begin
        if (mq.size() == 0) begin
          chk("unexpected_out_valid", 64'(out_valid), 64'(0));
        end else begin
          chk("out_sum",   64'(out_sum),   64'(mq[0].sum));
          chk("out_carry", 64'(out_carry), 64'(mq[0].carry));
          chk("out_ovf",   64'(out_ovf),   64'(mq[0].ovf));
          if (out_ready) begin
            if (mq[0].lat) chk("latency", 64'(cyc - mq[0].cyc), 64'(MAIN_ST));
            void'(mq.pop_front());
            occ--;
          end
        end
      end
      if (in_valid && in_ready) occ++;
    end
  end

  // Sweep instances: full throughput, one shared random stream.
  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 32;
    logic         rdy;
    logic         ov;
    logic [W-1:0] os;
    logic         oc;
    logic         oo;
    exp_t         q[$];
    exp_t         e;
    int           got = 0;

    pipelined_carry_adder #(.WIDTH(W), .STAGES(ST)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (sw_valid),
      .in_ready  (rdy),
      .in_a      (sw_a),
      .in_b      (sw_b),
      .in_sub    (sw_sub),
      .in_cin    (sw_cin),
      .out_valid (ov),
      .out_ready (1'b1),
      .out_sum   (os),
      .out_carry (oc),
      .out_ovf   (oo)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        q.delete();
      end else begin
        if (ov) begin
          if (q.size() == 0) begin
            chk($sformatf("sw%0d_unexpected", ST), 64'(ov), 64'(0));
          end else begin
            chk($sformatf("sw%0d_sum", ST),     64'(os), 64'(q[0].sum));
            chk($sformatf("sw%0d_carry", ST),   64'(oc), 64'(q[0].carry));
            chk($sformatf("sw%0d_ovf", ST),     64'(oo), 64'(q[0].ovf));
            chk($sformatf("sw%0d_latency", ST), 64'(cyc - q[0].cyc), 64'(ST));
            void'(q.pop_front());
            got++;
          end
        end
        if (sw_valid) begin
          chk($sformatf("sw%0d_in_ready", ST), 64'(rdy), 64'(1));
          e     = model(sw_a, sw_b, sw_sub, sw_cin);
          e.cyc = cyc;
          q.push_back(e);
        end
      end
    end

    always @(posedge sw_done) begin
      chk($sformatf("sw%0d_count", ST),   64'(got), 64'(N_SW));
      chk($sformatf("sw%0d_drained", ST), 64'(q.size()), 64'(0));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_sub    = 1'b0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    sw_valid  = 1'b0;
    sw_a      = '0;
    sw_b      = '0;
    sw_sub    = 1'b0;
    sw_cin    = 1'b0;
    sw_done   = 1'b0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", 64'(out_valid), 64'(0));
    chk("reset_out_sum",   64'(out_sum),   64'(0));
    chk("reset_out_carry", 64'(out_carry), 64'(0));
    chk("reset_out_ovf",   64'(out_ovf),   64'(0));
    rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    // Directed vectors, back to back, hand-computed results
    lat_en = 1'b1;
    send(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b0));
    send(32'h00000005, 32'h00000007, 1'b1, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0));
    send(32'h00000007, 32'h00000005, 1'b1, 1'b0, mk(32'h00000002, 1'b1, 1'b0));
    send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, mk(32'h80000000, 1'b0, 1'b1));
    send(32'h80000000, 32'h80000000, 1'b0, 1'b0, mk(32'h00000000, 1'b1, 1'b1));
    send(32'h12345678, 32'h11111111, 1'b0, 1'b1, mk(32'h2345678A, 1'b0, 1'b0));
    send(32'h80000000, 32'h00000001, 1'b1, 1'b0, mk(32'h7FFFFFFF, 1'b1, 1'b1));
    send(32'h00000007, 32'h00000005, 1'b1, 1'b1, mk(32'h00000002, 1'b1, 1'b0));
    drain();

    // Backpressure: 10 back-to-back entries, out_ready low for cycles 5-9
    lat_en    = 1'b0;
    saw_stall = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          send(bp_a[i], bp_b[i], bp_sub[i], bp_cin[i], model(bp_a[i], bp_b[i], bp_sub[i], bp_cin[i]));
        end
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_in_ready_dropped", 64'(saw_stall), 64'(1));

    // Reset with 3 entries in flight, one of them presented at the output
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send(bp_a[i], bp_b[i], bp_sub[i], bp_cin[i], model(bp_a[i], bp_b[i], bp_sub[i], bp_cin[i]));
    end
    @(posedge clk); #1;
    chk("pre_reset_out_valid", 64'(out_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", 64'(out_valid), 64'(0));
    mq.delete();
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lat_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(32'h00000005, 32'h00000007, 1'b1, 1'b0, mk(32'hFFFFFFFE, 1'b0, 1'b0));
    drain();

    // STAGES sweep at full throughput
    for (int i = 0; i < N_SW; i++) begin
      sw_a     = $urandom;
      sw_b     = $urandom;
      sw_sub   = 1'($urandom);
      sw_cin   = 1'($urandom);
      sw_valid = 1'b1;
      @(posedge clk); #1;
    end
    sw_valid = 1'b0;
    repeat (40) @(posedge clk);
    #1 sw_done = 1'b1;
    #2;

    chk("main_queue_empty", 64'(mq.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_carry_adder.md
Name: pipelined_carry_adder

Overview:
- Parametrised successor of the team's combinational FA-based ripple adder.
- Splits a WIDTH-bit add or subtract into STAGES registered ripple slices, giving a short carry chain per cycle.
- Elastic valid/ready pipeline: one result per cycle, with backpressure.
- Sits between operand buffers and the matrix-multiplier accumulate path.

Parameters:
- WIDTH, 32: operand and sum width in bits; must be divisible by STAGES.
- STAGES, 4: number of pipeline slices; CHUNK = WIDTH/STAGES bits per slice; 1 <= STAGES <= WIDTH.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands present.
- in_ready  out  1  pipeline accepts operands this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 gives A+B; 1 gives A-B.
- in_cin  in  1  carry-in, used only when in_sub=0.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_carry  out  1  carry out of the MSB; in subtract mode 1 means no borrow.
- out_ovf  out  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (async assert, sync-released by the system):
  - All stage valid bits = 0, so out_valid = 0.
  - out_sum, out_carry and out_ovf = 0.
  - in_ready = 1 once reset is deasserted.
- Operand conditioning at entry:
  - B' = in_sub ? ~in_b : in_b.
  - c0 = in_sub ? 1 : in_cin.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and B' with the carry registered from stage k-1 (c0 for k=0).
  - Registers the slice sum, the carry out, and all not-yet-consumed upper operand bits (skew registers).
  - Lower sum slices are forwarded unchanged.
- Last stage also registers out_ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Latency: exactly STAGES cycles from an accepted input to out_valid, with no stalls.
- Throughput: 1 result per cycle while out_ready = 1.
- Handshake:
  - A transfer occurs on the rising edge when valid & ready.
  - ready[k] = !valid[k] | ready[k+1], with ready[STAGES] = out_ready and in_ready = ready[0].
  - Bubbles collapse: an empty stage accepts even while downstream is stalled.
  - Stage k loads when ready[k]; it holds its data when valid[k] & !ready[k+1].
  - Its valid bit clears when it forwards with no new entry.
- Output hold: while out_valid = 1 and out_ready = 0, out_sum, out_carry and out_ovf are stable.
- in_ready must not depend combinationally on in_valid.
- Full pipeline (STAGES entries) with out_ready = 0: in_ready = 0; no entry is dropped or duplicated.
- Simultaneous accept and emit when full: permitted; occupancy is unchanged.
- Wrap-around: the sum is mod 2^WIDTH; the overflow indication appears only on out_carry and out_ovf.
- Reset mid-operation: all in-flight entries are discarded; no stale result appears after release.
- STAGES = 1: degenerates to a single registered ripple adder with latency 1.

Decomposition:
- project_pkg holds:
  - Default WIDTH and STAGES constants.
  - CHUNK derived constant.
  - Typedef word_t = logic [WIDTH-1:0].
  - Typedef stage_t packed struct: valid, a, b, sum, carry.
  - Elaboration-time check function for WIDTH % STAGES == 0.
- Sub-module adder_slice (parameter CHUNK): purely combinational CHUNK-bit ripple built from the existing FA cell.
  - Outputs: sum, carry out, and carry into its MSB (for overflow).
  - Instantiated once per stage via generate.

Test Plan:
- WIDTH=32, STAGES=4, add 0xFFFFFFFF + 0x00000001, cin=0 -> after 4 cycles: sum 0x00000000, carry 1, ovf 0.
- Subtract 5 - 7 -> sum 0xFFFFFFFE, carry 0 (borrow), ovf 0. Subtract 7 - 5 -> sum 0x00000002, carry 1.
- Add 0x7FFFFFFF + 0x00000001 -> sum 0x80000000, carry 0, ovf 1. Add 0x80000000 + 0x80000000 -> sum 0, carry 1, ovf 1.
- Backpressure: stream 10 random pairs back-to-back with out_ready low on cycles 5-9.
  - in_ready drops after 4 entries are held.
  - Outputs are held stable while stalled.
  - All 10 results arrive in order and match the reference model.
- Reset asserted mid-stream with 3 entries in flight -> out_valid drops immediately; after release no result emerges until a new input is accepted, STAGES cycles later.
- Sweep STAGES in {1, 2, 8, 32} with 1000 random add/sub/cin vectors at full throughput -> one result per cycle, latency = STAGES, zero mismatches.
